act_writeback: RTL

- Consumer at the output end of the activation path: takes the post-ReLU conv byte stream or mul tiles and writes them into the output activation SRAM.
- CONV: packs consecutive bytes little-endian into WIDTH-byte words and writes each word when it fills.
- MUL: serializes one latched HEIGHT x WIDTH tile into row writes, masking to the valid b_w x b_h region.
- Drives the output SRAM write port directly, with a word address counter that restarts at each layer load.

---
 rtl/act_writeback.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/act_writeback.sv
// act_writeback: packs post-ReLU conv bytes or serializes mul tiles into output activation SRAM writes
`ifndef CONV
`define CONV 1'b0
`endif
`ifndef MUL
`define MUL 1'b1
`endif
module act_writeback #(
  parameter int HEIGHT = 8,
  parameter int WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                load_layer_info,
  input  logic                                op_sel,
  input  logic [ADDR_WIDTH-1:0]               out_base_addr,
  input  logic [3:0]                          mul_b_w,
  input  logic [3:0]                          mul_b_h,
  input  logic                                conv_iv,
  input  logic [DATA_WIDTH-1:0]               conv_id,
  input  logic                                mul_iv,
  input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0]  mul_id,
  input  logic                                flush,
  output logic                                mul_ready,
  output logic                                mem_we,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [WIDTH*DATA_WIDTH-1:0]         mem_wd,
  output logic [WIDTH-1:0]                    mem_wstrb,
  output logic                                layer_done,
  output logic                                overflow_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam int LW = $clog2(WIDTH);
  localparam int HW = $clog2(HEIGHT);
  localparam int WW = WIDTH * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, DONE_WAIT} state_t;

  state_t                           state_q, state_d;
  logic                             op_q, op_d;
  logic [CW-1:0]                    bw_q, bw_d;
  logic [RW-1:0]                    bh_q, bh_d;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [WIDTH-1:0][DATA_WIDTH-1:0] pack_q, pack_d, pack_new;
  logic                             cwe_q, cwe_d;
  logic [ADDR_WIDTH-1:0]            caddr_q, caddr_d;
  logic [WW-1:0]                    cwd_q, cwd_d;
  logic [WIDTH-1:0]                 cstrb_q, cstrb_d;
  logic                             cpend_q, cpend_d;
  logic                             done_q, done_d;
  logic [RW-1:0]                    row_q, row_d;
  logic [HEIGHT-1:0][WW-1:0]        tile_q, tile_d;
  logic                             fpend_q, fpend_d;
  logic                             ovf_q, ovf_d;
  logic                             rdy_q, rdy_d;
  logic                             conv_take, row_last, mul_we;
  logic [CW-1:0]                    conv_new;
  logic [WIDTH-1:0]                 conv_mask, mul_mask;

  assign conv_take = conv_iv && op_q == `CONV;
  assign conv_new  = cnt_q + CW'(conv_take);
  assign row_last  = row_q == bh_q - RW'(1);
  assign mul_we    = state_q == WRITE;

  // Buffer contents as they would be after this cycle's conv byte lands
  always_comb begin
    pack_new = pack_q;
    if (conv_take) pack_new[cnt_q[LW-1:0]] = conv_id;
  end

  // Lane strobes: filled conv lanes, and the valid b_w columns of a tile row
  always_comb begin
    conv_mask = '0;
    mul_mask  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      conv_mask[k] = CW'(k) < conv_new;
      mul_mask[k]  = CW'(k) < bw_q;
    end
  end

  // Next-state: layer load, conv packing/flush, and the mul tile FSM
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bw_d    = bw_q;
    bh_d    = bh_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    cwe_d   = 1'b0;
    caddr_d = '0;
    cwd_d   = '0;
    cstrb_d = '0;
    cpend_d = 1'b0;
    done_d  = cpend_q;
    row_d   = row_q;
    tile_d  = tile_q;
    fpend_d = fpend_q;
    ovf_d   = ovf_q;
    if (load_layer_info) begin
      op_d    = op_sel;
      bw_d    = mul_b_w == 4'd0 ? CW'(WIDTH) : CW'(mul_b_w);
      bh_d    = mul_b_h == 4'd0 ? RW'(HEIGHT) : RW'(mul_b_h);
      addr_d  = out_base_addr;
      cnt_d   = '0;
      pack_d  = '0;
      ovf_d   = 1'b0;
      state_d = IDLE;
      row_d   = '0;
      fpend_d = 1'b0;
      done_d  = 1'b0;
    end else if (op_q == `CONV) begin
      pack_d = pack_new;
      cnt_d  = conv_new;
      if (conv_new == CW'(WIDTH) || (flush && conv_new != '0)) begin
        cwe_d   = 1'b1;
        caddr_d = addr_q;
        cwd_d   = pack_new;
        cstrb_d = conv_mask;
        cpend_d = flush;
        addr_d  = addr_q + ADDR_WIDTH'(1);
        cnt_d   = '0;
        pack_d  = '0;
      end else if (flush) begin
        done_d = 1'b1;
      end
    end else begin
      if (mul_iv && !rdy_q) ovf_d = 1'b1;
      if (state_q == IDLE) begin
        if (mul_iv && rdy_q) begin
          tile_d  = mul_id;
          row_d   = '0;
          fpend_d = flush;
          state_d = WRITE;
        end else if (flush) begin
          done_d = 1'b1;
        end
      end else if (state_q == WRITE) begin
        row_d   = row_q + RW'(1);
        fpend_d = fpend_q | flush;
        if (row_last) begin
          row_d   = '0;
          addr_d  = addr_q + ADDR_WIDTH'(bh_q);
          fpend_d = 1'b0;
          state_d = (fpend_q || flush) ? DONE_WAIT : IDLE;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign rdy_d = state_d == IDLE;

  // State registers; reset abandons any tile in flight
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      bw_q    <= '0;
      bh_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      pack_q  <= '0;
      cwe_q   <= 1'b0;
      caddr_q <= '0;
      cwd_q   <= '0;
      cstrb_q <= '0;
      cpend_q <= 1'b0;
      done_q  <= 1'b0;
      row_q   <= '0;
      tile_q  <= '0;
      fpend_q <= 1'b0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bw_q    <= bw_d;
      bh_q    <= bh_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      cwe_q   <= cwe_d;
      caddr_q <= caddr_d;
      cwd_q   <= cwd_d;
      cstrb_q <= cstrb_d;
      cpend_q <= cpend_d;
      done_q  <= done_d;
      row_q   <= row_d;
      tile_q  <= tile_d;
      fpend_q <= fpend_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end

  assign mul_ready    = rdy_q;
  assign mem_we       = cwe_q | mul_we;
  assign mem_addr     = mul_we ? addr_q + ADDR_WIDTH'(row_q) : caddr_q;
  assign mem_wd       = mul_we ? tile_q[row_q[HW-1:0]] : cwd_q;
  assign mem_wstrb    = mul_we ? mul_mask : cstrb_q;
  assign layer_done   = done_q | (state_q == DONE_WAIT);
  assign overflow_err = ovf_q;
endmodule
